rf_wb_controller: RTL and testbench
===================================

# rf_wb_controller

Write-back controller for the integer register file. It shares the file's single write port between two result producers, the ALU and the load/store unit (LSU), using valid/ready handshakes and starvation-limited priority. It also keeps a per-register busy scoreboard that decode uses to stall on pending writes. It sits between the execute/memory stages and the register file's wr_en/wr_index/wr_data port.

## Interface
- WIDTH, 32, data width of a register
- SIZE, 32, number of architectural registers; index width IW = $clog2(SIZE)
- STARVE_MAX, 4, consecutive ALU-wait cycles before the ALU overrides LSU priority; legal range ≥1
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-high
- issue_valid  in  1  decode dispatches an instruction that writes issue_rd
- issue_rd  in  IW  destination register of the dispatched instruction
- issue_ready  out  1  dispatch allowed: issue_rd==0 or !busy[issue_rd]
- alu_valid / alu_ready  in / out  1  ALU result handshake
- alu_index  in  IW  ALU destination
- alu_data  in  WIDTH  ALU result
- lsu_valid / lsu_ready  in / out  1  LSU result handshake
- lsu_index  in  IW  LSU destination
- lsu_data  in  WIDTH  load result
- wr_en  out  1  register-file write enable (registered)
- wr_index  out  IW  register-file write index (registered)
- wr_data  out  WIDTH  register-file write data (registered)
- busy  out  SIZE  scoreboard; bit i set means a write to register i is outstanding; bit 0 is always 0

## Operation
- A handshake occurs on a rising edge when valid && ready are both high. At most one producer is granted per cycle.
- Grant rules (combinational, evaluated each cycle):
  - If starve_cnt==STARVE_MAX and alu_valid, grant the ALU.
  - Otherwise, if lsu_valid, grant the LSU.
  - Otherwise, if alu_valid, grant the ALU.
  - Otherwise, no grant.
- alu_ready and lsu_ready equal their grant bits. A ready may rise only while the matching valid is high.
- Producers hold valid, index and data stable until the handshake completes.
- starve_cnt holds 0..STARVE_MAX:
  - Increments (saturating) on each edge where alu_valid && !alu_ready.
  - Clears on an ALU handshake or whenever alu_valid is low.
- On a handshake with index≠0, the next edge loads wr_en=1, wr_index=index and wr_data=data.
- With no handshake, or a handshake with index==0, the next edge loads wr_en=0. An index-0 result is accepted and discarded.
- wr_index and wr_data hold their last value when wr_en=0.
- Scoreboard:
  - An issue handshake (issue_valid && issue_ready, issue_rd≠0) sets busy[issue_rd] on the edge.
  - A producer handshake with index≠0 clears busy[index] on the edge.
  - If a set and a clear hit the same index in the same cycle, the set wins.
  - Issuing to a busy register stalls (issue_ready=0). There is no write-after-write overlap.
- A producer write to a non-busy register is legal. It clears nothing and is written normally.

## Timing
- Reset values (asynchronous): wr_en=0, wr_index=0, wr_data=0, busy=0, starve_cnt=0.
- During reset: alu_ready=0, lsu_ready=0, issue_ready=0.
- Reset asserted mid-operation drops every pending handshake and busy bit. Producers re-present after reset deasserts.
- Write latency: handshake at edge N → wr_en high in cycle N..N+1 → register file updated at edge N+1. Throughput is one write per cycle.
- Busy clears at the handshake edge N. Decode may re-issue to that register at edge N+1. Operand read/bypass of the value in flight is decode's responsibility.
- issue_ready is combinational from busy and issue_rd. There is no internal path from issue_* to the producer readies.

## Structure
- Package rf_wb_pkg holds:
  - typedef enum logic [1:0] {GNT_NONE, GNT_ALU, GNT_LSU} grant_t
  - default WIDTH/SIZE/STARVE_MAX localparams
- Sub-module rf_scoreboard: busy vector, set/clear with set-wins priority, and the issue_ready lookup.
- The top level holds the arbiter, starve_cnt and the write-port output registers.

## Test plan
- Reset, then ALU only: alu_valid with index=5, data=0xDEADBEEF → alu_ready=1 that cycle; next cycle wr_en=1, wr_index=5, wr_data=0xDEADBEEF; then wr_en=0.
- Conflict: ALU (x3) and LSU (x4) valid together → LSU granted first, ALU on the following cycle; write port shows x4 then x3 on consecutive cycles.
- Starvation: alu_valid and lsu_valid held high for 10 cycles → ALU granted on its 5th waiting cycle (STARVE_MAX=4); starve_cnt returns to 0 afterwards.
- Scoreboard: issue x7 → busy[7]=1; a second issue of x7 sees issue_ready=0; LSU write x7 → busy[7]=0 at that edge and issue_ready=1 next cycle. Also: issue x9 and write x9 in the same cycle → busy[9] stays 1.
- x0 handling: issue_rd=0 leaves busy=0 with issue_ready=1; ALU write to index 0 is accepted but wr_en stays 0.
- Reset mid-flight: busy[2]=1 with lsu_valid held and not yet granted; assert reset between edges → busy=0, wr_en=0 and readies low immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rf_wb_pkg.sv
// Shared types and default sizing for the register-file write-back controller.
package rf_wb_pkg;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_SIZE       = 32;
    localparam int DEF_STARVE_MAX = 4;

    typedef enum logic [1:0] {GNT_NONE, GNT_ALU, GNT_LSU} grant_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: set on issue, clear on write-back (set wins); busy visible next cycle.
// issue_ready lookup is combinational and forced low while reset is asserted.
module rf_scoreboard
    import rf_wb_pkg::*;
#(
    parameter int SIZE = DEF_SIZE
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     set_en,
    input  logic [$clog2(SIZE)-1:0]  set_index,
    input  logic                     clr_en,
    input  logic [$clog2(SIZE)-1:0]  clr_index,
    input  logic [$clog2(SIZE)-1:0]  query_index,
    output logic                     query_ready,
    output logic [SIZE-1:0]          busy
);

    logic [SIZE-1:0] busy_nxt;

    // Set is applied after clear so a same-index collision leaves the bit set.
    always_comb begin
        busy_nxt = busy;
        if (clr_en) busy_nxt[clr_index] = 1'b0;
        if (set_en) busy_nxt[set_index] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) busy <= '0;
        else       busy <= busy_nxt;
    end

    assign query_ready = !reset && ((query_index == '0) || !busy[query_index]);

endmodule

// File: rtl/rf_wb_controller.sv
// Arbitrates ALU/LSU results onto the single register-file write port; one-cycle registered write.
// LSU has priority unless the ALU has waited STARVE_MAX cycles; readies follow grants, low in reset.
module rf_wb_controller
    import rf_wb_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int SIZE       = DEF_SIZE,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     issue_valid,
    input  logic [$clog2(SIZE)-1:0]  issue_rd,
    output logic                     issue_ready,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [$clog2(SIZE)-1:0]  alu_index,
    input  logic [WIDTH-1:0]         alu_data,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [$clog2(SIZE)-1:0]  lsu_index,
    input  logic [WIDTH-1:0]         lsu_data,
    output logic                     wr_en,
    output logic [$clog2(SIZE)-1:0]  wr_index,
    output logic [WIDTH-1:0]         wr_data,
    output logic [SIZE-1:0]          busy
);

    localparam int IW = $clog2(SIZE);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    grant_t          grant;
    logic [SW-1:0]   starve_cnt;
    logic [IW-1:0]   sel_index;
    logic [WIDTH-1:0] sel_data;
    logic            handshake;
    logic            do_write;
    logic            issue_set;

    always_comb begin
        grant = GNT_NONE;
        if (!reset) begin
            if (alu_valid && starve_cnt == STARVE_LIM) grant = GNT_ALU;
            else if (lsu_valid)                        grant = GNT_LSU;
            else if (alu_valid)                        grant = GNT_ALU;
        end
    end

    assign alu_ready = (grant == GNT_ALU);
    assign lsu_ready = (grant == GNT_LSU);
    assign handshake = (grant != GNT_NONE);
    assign sel_index = (grant == GNT_LSU) ? lsu_index : alu_index;
    assign sel_data  = (grant == GNT_LSU) ? lsu_data  : alu_data;
    // Index-0 results complete the handshake but never reach the register file.
    assign do_write  = handshake && (sel_index != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (alu_valid && !alu_ready) begin
            if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + SW'(1);
        end else begin
            starve_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en    <= 1'b0;
            wr_index <= '0;
            wr_data  <= '0;
        end else begin
            wr_en <= do_write;
            if (do_write) begin
                wr_index <= sel_index;
                wr_data  <= sel_data;
            end
        end
    end

    assign issue_set = issue_valid && issue_ready && (issue_rd != '0);

    rf_scoreboard #(.SIZE(SIZE)) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .set_en      (issue_set),
        .set_index   (issue_rd),
        .clr_en      (do_write),
        .clr_index   (sel_index),
        .query_index (issue_rd),
        .query_ready (issue_ready),
        .busy        (busy)
    );

endmodule

// File: tb/tb_rf_wb_controller.sv
// Directed bench for rf_wb_controller with a cycle-level reference model checked every negedge.
module tb_rf_wb_controller;

    localparam int WIDTH      = 32;
    localparam int SIZE       = 32;
    localparam int IW         = 5;
    localparam int STARVE_MAX = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             issue_valid = 1'b0;
    logic [IW-1:0]    issue_rd = '0;
    logic             issue_ready;
    logic             alu_valid = 1'b0;
    logic             alu_ready;
    logic [IW-1:0]    alu_index = '0;
    logic [WIDTH-1:0] alu_data = '0;
    logic             lsu_valid = 1'b0;
    logic             lsu_ready;
    logic [IW-1:0]    lsu_index = '0;
    logic [WIDTH-1:0] lsu_data = '0;
    logic             wr_en;
    logic [IW-1:0]    wr_index;
    logic [WIDTH-1:0] wr_data;
    logic [SIZE-1:0]  busy;

    int tests = 0;
    int fails = 0;

    rf_wb_controller #(.WIDTH(WIDTH), .SIZE(SIZE), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_index(alu_index), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_index(lsu_index), .lsu_data(lsu_data),
        .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: set of pending registers, ALU wait length, and the last accepted write.
    logic [SIZE-1:0]  m_busy = '0;
    int               m_wait = 0;
    logic             m_wr_en = 1'b0;
    logic [IW-1:0]    m_wr_index = '0;
    logic [WIDTH-1:0] m_wr_data = '0;
    logic             ea, el, ei, ga, gl, issue_ok;
    logic [IW-1:0]    m_idx;
    logic [WIDTH-1:0] m_dat;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = '0; m_wait = 0; m_wr_en = 1'b0; m_wr_index = '0; m_wr_data = '0;
        end else begin
            ga = alu_valid && (m_wait >= STARVE_MAX || !lsu_valid);
            gl = lsu_valid && !ga;
            m_idx = gl ? lsu_index : alu_index;
            m_dat = gl ? lsu_data : alu_data;
            issue_ok = issue_valid && issue_rd != 0 && !m_busy[issue_rd];
            m_wr_en = (ga || gl) && m_idx != 0;
            if (m_wr_en) begin
                m_wr_index = m_idx;
                m_wr_data  = m_dat;
                m_busy[m_idx] = 1'b0;
            end
            if (issue_ok) m_busy[issue_rd] = 1'b1;
            m_wait = (alu_valid && !ga) ? m_wait + 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            ea = 1'b0; el = 1'b0; ei = 1'b0;
        end else begin
            ea = alu_valid && (m_wait >= STARVE_MAX || !lsu_valid);
            el = lsu_valid && !ea;
            ei = (issue_rd == 0) || !m_busy[issue_rd];
        end
        check("model_alu_ready", alu_ready, ea);
        check("model_lsu_ready", lsu_ready, el);
        check("model_issue_ready", issue_ready, ei);
        check("model_wr_en", wr_en, m_wr_en);
        check("model_wr_index", wr_index, m_wr_index);
        check("model_wr_data", wr_data, m_wr_data);
        check("model_busy", busy, m_busy);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int first_alu;
    int alu_grants;

    initial begin
        tick(); tick();
        #1;
        check("reset_wr_en", wr_en, 0);
        check("reset_busy", busy, 0);
        check("reset_lsu_ready", lsu_ready, 0);
        check("reset_issue_ready", issue_ready, 0);
        reset = 1'b0;
        tick();

        // ALU only
        alu_valid = 1; alu_index = 5; alu_data = 32'hDEADBEEF;
        #2 check("alu_only_ready", alu_ready, 1);
        tick(); alu_valid = 0;
        #2;
        check("alu_only_wr_en", wr_en, 1);
        check("alu_only_wr_index", wr_index, 5);
        check("alu_only_wr_data", wr_data, 32'hDEADBEEF);
        tick();
        #2;
        check("alu_only_wr_en_drop", wr_en, 0);
        check("alu_only_hold_data", wr_data, 32'hDEADBEEF);

        // Conflict: LSU first, ALU next
        alu_valid = 1; alu_index = 3; alu_data = 32'hA3;
        lsu_valid = 1; lsu_index = 4; lsu_data = 32'hB4;
        #2;
        check("conflict_lsu_first", lsu_ready, 1);
        check("conflict_alu_waits", alu_ready, 0);
        tick(); lsu_valid = 0;
        #2;
        check("conflict_alu_second", alu_ready, 1);
        check("conflict_wr_x4", wr_index, 4);
        tick(); alu_valid = 0;
        #2;
        check("conflict_wr_x3", wr_index, 3);
        check("conflict_wr_x3_data", wr_data, 32'hA3);
        tick();

        // Starvation
        alu_valid = 1; alu_index = 6; alu_data = 32'h66;
        lsu_valid = 1; lsu_index = 8; lsu_data = 32'h88;
        first_alu = 0; alu_grants = 0;
        for (int i = 1; i <= 10; i++) begin
            #2;
            if (alu_ready) begin
                alu_grants++;
                if (first_alu == 0) first_alu = i;
            end
            tick();
        end
        check("starve_first_alu_cycle", first_alu, 5);
        check("starve_alu_grants", alu_grants, 2);
        #2 check("starve_cleared_lsu_wins", lsu_ready, 1);
        tick(); alu_valid = 0; lsu_valid = 0;
        tick();

        // Scoreboard
        issue_valid = 1; issue_rd = 7;
        #2 check("sb_issue7_ready", issue_ready, 1);
        tick();
        #2;
        check("sb_busy7_set", busy[7], 1);
        check("sb_reissue7_stall", issue_ready, 0);
        issue_valid = 0;
        lsu_valid = 1; lsu_index = 7; lsu_data = 32'h77;
        tick(); lsu_valid = 0;
        #2;
        check("sb_busy7_cleared", busy[7], 0);
        check("sb_issue7_ready_again", issue_ready, 1);
        tick();
        issue_valid = 1; issue_rd = 9;
        alu_valid = 1; alu_index = 9; alu_data = 32'h99;
        tick(); issue_valid = 0; alu_valid = 0;
        #2 check("sb_set_wins_busy9", busy[9], 1);
        tick();

        // x0 handling
        issue_valid = 1; issue_rd = 0;
        #2 check("x0_issue_ready", issue_ready, 1);
        tick(); issue_valid = 0;
        #2 check("x0_busy0_clear", busy[0], 0);
        alu_valid = 1; alu_index = 0; alu_data = 32'h1234;
        #0 check("x0_alu_accepted", alu_ready, 1);
        tick(); alu_valid = 0;
        #2 check("x0_no_write", wr_en, 0);
        tick();

        // Reset mid-flight
        issue_valid = 1; issue_rd = 2;
        alu_valid = 1; alu_index = 11; alu_data = 32'hBB;
        tick();
        issue_valid = 0; alu_valid = 0;
        lsu_valid = 1; lsu_index = 2; lsu_data = 32'h22;
        #1;
        check("pre_reset_busy2", busy[2], 1);
        check("pre_reset_wr_en", wr_en, 1);
        reset = 1'b1;
        #1;
        check("async_reset_busy", busy, 0);
        check("async_reset_wr_en", wr_en, 0);
        check("async_reset_lsu_ready", lsu_ready, 0);
        check("async_reset_issue_ready", issue_ready, 0);
        tick(); tick();
        reset = 1'b0; lsu_valid = 0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
